// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Holds the sequencer state encoding, master index constants and the
// default bus widths used by the interface and the arbiter top.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // One-hot mask for a master index, used to exclude the acked master.
  function automatic logic [1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester channels, the shared memory port and the
// status outputs of the memory port arbiter. The slave modport is the
// arbiter's view; the master modport is the view of the surrounding system.
interface mem_bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;
  logic              busy;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output owner, busy
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  owner, busy
  );

endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational two-input picker. A master is eligible when it requests
// and is not masked off; with both eligible the one that differs from the
// pointer wins, so a pointer tied to 1 gives fixed priority to master 0.
module arb_pick
  import bus_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic [1:0] excl_i,
  output logic       valid_o,
  output logic       idx_o
);

  logic [1:0] eligible;

  assign eligible = req_i & ~excl_i;

  // Resolve the winner among the eligible requesters.
  always_comb begin
    valid_o = |eligible;
    idx_o   = M_CPU;
    case (eligible)
      2'b01:   idx_o = M_CPU;
      2'b10:   idx_o = M_DMA;
      2'b11:   idx_o = ~ptr_i;
      default: idx_o = M_CPU;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and sequencer for the data-memory/peripheral port.
// Each access runs IDLE -> ACCESS -> RESP; in RESP the acked master is
// masked so the other one can go straight into the next ACCESS.
// Optional build macro ARB_RR_EN: adds a last-grant pointer so that
// simultaneous requests in IDLE alternate; without it master 0 wins.
module mem_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              busy_q;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        req_vec;
  logic [1:0]        excl_mask;
  logic              grant_valid;
  logic              grant_idx;
  logic              ptr;
  logic              ack_resp;

  assign req_vec   = {bus.m1_req, bus.m0_req};
  assign excl_mask = (state_q == RESP) ? idx_onehot(owner_q) : 2'b00;

  arb_pick u_pick (
    .req_i   (req_vec),
    .ptr_i   (ptr),
    .excl_i  (excl_mask),
    .valid_o (grant_valid),
    .idx_o   (grant_idx)
  );

`ifdef ARB_RR_EN
  logic ptr_q;
  logic grant_take;

  assign grant_take = grant_valid && (state_q != ACCESS);
  assign ptr        = ptr_q;

  // Remember the most recent grant so the next tie goes the other way.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b1;
    end else if (grant_take) begin
      ptr_q <= grant_idx;
    end
  end
`else
  assign ptr = 1'b1;
`endif

  // Sequencer next state plus loading of the command and response registers.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cmd_wr_d = cmd_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (grant_valid) begin
          state_d  = ACCESS;
          owner_d  = grant_idx;
          cmd_wr_d = grant_idx ? bus.m1_wr    : bus.m0_wr;
          addr_d   = grant_idx ? bus.m1_addr  : bus.m0_addr;
          wdata_d  = grant_idx ? bus.m1_wdata : bus.m0_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = cmd_wr_q ? '0 : bus.mem_rdata;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, command and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= M_CPU;
      busy_q   <= 1'b0;
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      busy_q   <= (state_d != IDLE);
      cmd_wr_q <= cmd_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ack_resp = (state_q == RESP) && !reset;

  assign bus.mem_rd    = (state_q == ACCESS) && !cmd_wr_q && !reset;
  assign bus.mem_wr    = (state_q == ACCESS) &&  cmd_wr_q && !reset;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.m0_ack   = ack_resp && (owner_q == M_CPU);
  assign bus.m1_ack   = ack_resp && (owner_q == M_DMA);
  assign bus.m0_rdata = bus.m0_ack ? rdata_q : '0;
  assign bus.m1_rdata = bus.m1_ack ? rdata_q : '0;

  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios for reset, single
// read/write, simultaneous requests, pointer behaviour, streaming and reset
// mid-access, followed by randomized traffic from both masters checked
// against a reference memory and the arbiter's timing/fairness rules.
module tb_mem_bus_arbiter;
  import bus_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] memArr [0:255];
  logic [31:0] refMem [0:255];

  logic        curWr   [2];
  logic [31:0] curAddr [2];
  logic [31:0] curData [2];

`ifdef ARB_RR_EN
  localparam logic TIE_WINNER = 1'b1;
`else
  localparam logic TIE_WINNER = 1'b0;
`endif

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory behind the port: combinational read, write on the clock edge.
  assign bus.mem_rdata = memArr[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_wr) memArr[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setCmd(input int m, input logic req, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_wr = wr; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_wr = wr; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setCmd(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      total++;
      if ({bus.mem_rd, bus.mem_wr, bus.m0_ack, bus.m1_ack, bus.busy, bus.owner} !== 6'b0) begin
        bad++;
        $display("[TB] FAIL reset_ctrl: got %b want 000000",
                 {bus.mem_rd, bus.mem_wr, bus.m0_ack, bus.m1_ack, bus.busy, bus.owner});
      end
      total++;
      if ({bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata} !== 128'h0) begin
        bad++;
        $display("[TB] FAIL reset_data: got %h want 0",
                 {bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata});
      end
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.mem_rd, bus.busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_release_idle: got %b want 00", {bus.mem_rd, bus.busy});
    end
    cyc();
    @(negedge clk);
    total++;
    if ({bus.mem_rd, bus.mem_wr, bus.busy, bus.owner, bus.m0_ack, bus.mem_addr} !== {5'b10100, 32'h10}) begin
      bad++;
      $display("[TB] FAIL first_read_access: got %h want %h",
               {bus.mem_rd, bus.mem_wr, bus.busy, bus.owner, bus.m0_ack, bus.mem_addr}, {5'b10100, 32'h10});
    end
    @(negedge clk);
    total++;
    if ({bus.m0_ack, bus.m1_ack, bus.mem_rd, bus.busy, bus.m0_rdata, bus.m1_rdata} !== {4'b1001, 32'hDEAD_BEEF, 32'h0}) begin
      bad++;
      $display("[TB] FAIL first_read_ack: got %h want %h",
               {bus.m0_ack, bus.m1_ack, bus.mem_rd, bus.busy, bus.m0_rdata, bus.m1_rdata},
               {4'b1001, 32'hDEAD_BEEF, 32'h0});
    end
    cyc();
    setCmd(0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_single_read();
    setCmd(1, 1'b1, 1'b0, 32'h4000_0020, 32'h0);
    cyc();
    @(negedge clk);
    total++;
    if ({bus.mem_rd, bus.mem_wr, bus.owner, bus.busy, bus.mem_addr} !== {4'b1011, 32'h4000_0020}) begin
      bad++;
      $display("[TB] FAIL read_access: got %h want %h",
               {bus.mem_rd, bus.mem_wr, bus.owner, bus.busy, bus.mem_addr}, {4'b1011, 32'h4000_0020});
    end
    @(negedge clk);
    total++;
    if ({bus.m0_ack, bus.m1_ack, bus.m0_rdata, bus.m1_rdata} !== {2'b01, 32'h0, refMem[8]}) begin
      bad++;
      $display("[TB] FAIL read_ack: got %h want %h",
               {bus.m0_ack, bus.m1_ack, bus.m0_rdata, bus.m1_rdata}, {2'b01, 32'h0, refMem[8]});
    end
    cyc();
    setCmd(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_single_write();
    setCmd(1, 1'b1, 1'b1, 32'h4000_000C, 32'h1234_5678);
    cyc();
    @(negedge clk);
    total++;
    if ({bus.mem_rd, bus.mem_wr, bus.owner, bus.busy, bus.mem_addr, bus.mem_wdata} !==
        {4'b0111, 32'h4000_000C, 32'h1234_5678}) begin
      bad++;
      $display("[TB] FAIL write_access: got %h want %h",
               {bus.mem_rd, bus.mem_wr, bus.owner, bus.busy, bus.mem_addr, bus.mem_wdata},
               {4'b0111, 32'h4000_000C, 32'h1234_5678});
    end
    @(negedge clk);
    total++;
    if ({bus.m0_ack, bus.m1_ack, bus.mem_wr, bus.m1_rdata} !== {3'b010, 32'h0}) begin
      bad++;
      $display("[TB] FAIL write_ack: got %h want %h",
               {bus.m0_ack, bus.m1_ack, bus.mem_wr, bus.m1_rdata}, {3'b010, 32'h0});
    end
    cyc();
    setCmd(1, 1'b0, 1'b0, 32'h0, 32'h0);
    refMem[3] = 32'h1234_5678;
    total++;
    if (memArr[3] !== refMem[3]) begin
      bad++;
      $display("[TB] FAIL write_mem: got %h want %h", memArr[3], refMem[3]);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] a [2][2];
    logic [31:0] rd, ea;
    int issued [2];
    int acks;
    int m;
    a[0][0] = 32'h0000_0040; a[0][1] = 32'h0000_0044;
    a[1][0] = 32'h4000_0048; a[1][1] = 32'h4000_004C;
    issued[0] = 1; issued[1] = 1;
    acks = 0;
    setCmd(0, 1'b1, 1'b0, a[0][0], 32'h0);
    setCmd(1, 1'b1, 1'b0, a[1][0], 32'h0);
    for (int c = 0; c < 24 && acks < 4; c++) begin
      @(negedge clk);
      m = -1;
      if (bus.m0_ack || bus.m1_ack) begin
        m = bus.m1_ack ? 1 : 0;
        total++;
        if (m != (acks % 2)) begin
          bad++;
          $display("[TB] FAIL sim_order: ack %0d got master %0d want %0d", acks, m, acks % 2);
        end
        total++;
        if (c != 2 + 2 * acks) begin
          bad++;
          $display("[TB] FAIL sim_spacing: ack %0d got cycle %0d want %0d", acks, c, 2 + 2 * acks);
        end
        rd = m ? bus.m1_rdata : bus.m0_rdata;
        ea = a[m][issued[m] - 1];
        total++;
        if (rd !== refMem[ea[9:2]]) begin
          bad++;
          $display("[TB] FAIL sim_rdata: got %h want %h", rd, refMem[ea[9:2]]);
        end
        acks++;
      end
      cyc();
      if (m >= 0) begin
        if (issued[m] < 2) begin
          setCmd(m, 1'b1, 1'b0, a[m][issued[m]], 32'h0);
          issued[m]++;
        end else begin
          setCmd(m, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
    end
    total++;
    if (acks != 4) begin
      bad++;
      $display("[TB] FAIL sim_count: got %0d want 4", acks);
    end
    setCmd(0, 1'b0, 1'b0, 32'h0, 32'h0);
    setCmd(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_pointer();
    logic loser;
    loser = ~TIE_WINNER;
    setCmd(0, 1'b1, 1'b0, 32'h0000_0050, 32'h0);
    cyc();
    cyc();
    @(negedge clk);
    total++;
    if ({bus.m1_ack, bus.m0_ack} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL ptr_pre_ack: got %b want 01", {bus.m1_ack, bus.m0_ack});
    end
    cyc();
    setCmd(0, 1'b0, 1'b0, 32'h0, 32'h0);
    setCmd(0, 1'b1, 1'b0, 32'h0000_0054, 32'h0);
    setCmd(1, 1'b1, 1'b0, 32'h4000_0058, 32'h0);
    cyc();
    @(negedge clk);
    total++;
    if ({bus.owner, bus.mem_rd} !== {TIE_WINNER, 1'b1}) begin
      bad++;
      $display("[TB] FAIL ptr_tie_winner: got %b want %b", {bus.owner, bus.mem_rd}, {TIE_WINNER, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({bus.m1_ack, bus.m0_ack} !== idx_onehot(TIE_WINNER)) begin
      bad++;
      $display("[TB] FAIL ptr_tie_ack: got %b want %b", {bus.m1_ack, bus.m0_ack}, idx_onehot(TIE_WINNER));
    end
    cyc();
    setCmd(int'(TIE_WINNER), 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if ({bus.owner, bus.mem_rd} !== {loser, 1'b1}) begin
      bad++;
      $display("[TB] FAIL ptr_loser_access: got %b want %b", {bus.owner, bus.mem_rd}, {loser, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({bus.m1_ack, bus.m0_ack} !== idx_onehot(loser)) begin
      bad++;
      $display("[TB] FAIL ptr_loser_ack: got %b want %b", {bus.m1_ack, bus.m0_ack}, idx_onehot(loser));
    end
    cyc();
    setCmd(int'(loser), 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_streaming();
    logic [31:0] sAddr [4];
    logic [31:0] sData [4];
    int n, s;
    logic acked;
    for (int i = 0; i < 4; i++) begin
      sAddr[i] = 32'h0000_0050 + 32'(i * 4);
      sData[i] = $urandom;
    end
    n = 0; s = 0;
    setCmd(0, 1'b1, 1'b1, sAddr[0], sData[0]);
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      acked = 1'b0;
      if (bus.mem_wr && s < 4) begin
        total++;
        if ({bus.mem_addr, bus.mem_wdata} !== {sAddr[s], sData[s]}) begin
          bad++;
          $display("[TB] FAIL stream_strobe: got %h want %h", {bus.mem_addr, bus.mem_wdata}, {sAddr[s], sData[s]});
        end
        s++;
      end
      if (bus.m0_ack) begin
        total++;
        if (c != 2 + 3 * n || bus.m0_rdata !== 32'h0) begin
          bad++;
          $display("[TB] FAIL stream_ack: got cycle %0d rdata %h want cycle %0d rdata 0",
                   c, bus.m0_rdata, 2 + 3 * n);
        end
        refMem[sAddr[n][9:2]] = sData[n];
        n++;
        acked = 1'b1;
      end
      cyc();
      if (acked) begin
        if (n < 4) setCmd(0, 1'b1, 1'b1, sAddr[n], sData[n]);
        else       setCmd(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("[TB] FAIL stream_count: got %0d want 4", n);
    end
    setCmd(0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (memArr[sAddr[i][9:2]] !== refMem[sAddr[i][9:2]]) begin
        bad++;
        $display("[TB] FAIL stream_mem: got %h want %h", memArr[sAddr[i][9:2]], refMem[sAddr[i][9:2]]);
      end
    end
  endtask

  task automatic test_reset_access();
    setCmd(1, 1'b1, 1'b1, 32'h4000_0060, 32'hA5A5_A5A5);
    cyc();
    total++;
    if ({bus.busy, bus.owner} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL rst_mid_state: got %b want 11", {bus.busy, bus.owner});
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.mem_wr, bus.mem_rd} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rst_mid_strobe: got %b want 00", {bus.mem_wr, bus.mem_rd});
    end
    cyc();
    reset = 1'b0;
    setCmd(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({bus.m0_ack, bus.m1_ack, bus.busy, bus.owner, bus.mem_wr, bus.mem_rd} !== 6'b0) begin
        bad++;
        $display("[TB] FAIL rst_mid_after: got %b want 000000",
                 {bus.m0_ack, bus.m1_ack, bus.busy, bus.owner, bus.mem_wr, bus.mem_rd});
      end
    end
    total++;
    if (memArr[24] !== refMem[24]) begin
      bad++;
      $display("[TB] FAIL rst_mid_mem: got %h want %h", memArr[24], refMem[24]);
    end
  endtask

  task automatic driveMaster(input int m, input int n);
    int   k;
    logic holding, got, wr;
    logic [31:0] addr, data;
    k = 0;
    holding = 1'b0;
    while (k < n) begin
      if (!holding) repeat ($urandom_range(0, 3)) cyc();
      wr   = 1'($urandom_range(0, 1));
      addr = (32'($urandom_range(32, 47)) << 2) | ($urandom_range(0, 1) ? 32'h4000_0000 : 32'h0);
      data = $urandom;
      curWr[m] = wr; curAddr[m] = addr; curData[m] = data;
      setCmd(m, 1'b1, wr, addr, data);
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (m == 0 ? bus.m0_ack : bus.m1_ack) got = 1'b1;
      end
      total++;
      if (!got) begin
        bad++;
        $display("[TB] FAIL rand_timeout: master %0d got no ack want ack within 40 cycles", m);
      end
      cyc();
      k++;
      if (k < n && $urandom_range(0, 1) == 1) begin
        holding = 1'b1;
      end else begin
        holding = 1'b0;
        setCmd(m, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 8;
    logic        randDone, strobePending, strobeOwner, expNextValid, expNext, o;
    logic [1:0]  expAck;
    logic [31:0] rd, oth, want;
    int          ackCount [2];
    randDone = 1'b0; strobePending = 1'b0; strobeOwner = 1'b0;
    expNextValid = 1'b0; expNext = 1'b0;
    ackCount[0] = 0; ackCount[1] = 0;
    fork
      begin
        fork
          driveMaster(0, N);
          driveMaster(1, N);
        join
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(negedge clk);
          expAck = strobePending ? idx_onehot(strobeOwner) : 2'b00;
          total++;
          if ({bus.m1_ack, bus.m0_ack} !== expAck) begin
            bad++;
            $display("[TB] FAIL rand_ack: got %b want %b", {bus.m1_ack, bus.m0_ack}, expAck);
          end
          if (expNextValid) begin
            total++;
            if ({(bus.mem_rd | bus.mem_wr), bus.owner} !== {1'b1, expNext}) begin
              bad++;
              $display("[TB] FAIL rand_handover: got %b want %b",
                       {(bus.mem_rd | bus.mem_wr), bus.owner}, {1'b1, expNext});
            end
            expNextValid = 1'b0;
          end
          if (expAck != 2'b00) begin
            rd  = strobeOwner ? bus.m1_rdata : bus.m0_rdata;
            oth = strobeOwner ? bus.m0_rdata : bus.m1_rdata;
            if (curWr[strobeOwner]) begin
              want = 32'h0;
              refMem[curAddr[strobeOwner][9:2]] = curData[strobeOwner];
            end else begin
              want = refMem[curAddr[strobeOwner][9:2]];
            end
            total++;
            if ({rd, oth} !== {want, 32'h0}) begin
              bad++;
              $display("[TB] FAIL rand_rdata: got %h want %h", {rd, oth}, {want, 32'h0});
            end
            ackCount[strobeOwner]++;
            if (strobeOwner ? bus.m0_req : bus.m1_req) begin
              expNextValid = 1'b1;
              expNext = ~strobeOwner;
            end
          end
          if (bus.mem_rd || bus.mem_wr) begin
            o = bus.owner;
            total++;
            if ({bus.mem_rd, bus.mem_wr, bus.mem_addr, (curWr[o] ? bus.mem_wdata : 32'h0), (o ? bus.m1_req : bus.m0_req)} !==
                {~curWr[o], curWr[o], curAddr[o], (curWr[o] ? curData[o] : 32'h0), 1'b1}) begin
              bad++;
              $display("[TB] FAIL rand_strobe: got %h want %h",
                       {bus.mem_rd, bus.mem_wr, bus.mem_addr, (curWr[o] ? bus.mem_wdata : 32'h0), (o ? bus.m1_req : bus.m0_req)},
                       {~curWr[o], curWr[o], curAddr[o], (curWr[o] ? curData[o] : 32'h0), 1'b1});
            end
            strobePending = 1'b1;
            strobeOwner   = o;
          end else begin
            strobePending = 1'b0;
          end
        end
      end
    join
    for (int m = 0; m < 2; m++) begin
      total++;
      if (ackCount[m] != N) begin
        bad++;
        $display("[TB] FAIL rand_ack_count: master %0d got %0d want %0d", m, ackCount[m], N);
      end
    end
  endtask

  // Preload both memories with identical random contents.
  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = (i == 4) ? 32'hDEAD_BEEF : $urandom;
      memArr[i] <= v;
      refMem[i] = v;
    end
  end

  // Bound total run time in case a scenario wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    reset = 1'b1;
    setCmd(0, 1'b0, 1'b0, 32'h0, 32'h0);
    setCmd(1, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_single_read();
    test_single_write();
    test_simultaneous();
    test_pointer();
    test_streaming();
    test_reset_access();
    cyc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter and sequencer for the single data-memory/peripheral port of the pipelined CPU. It shares the port between master 0 (CPU MEM stage) and master 1 (UART DMA engine). Each access runs through a registered IDLE→ACCESS→RESP sequence. Address decode (DataMem vs Peripheral on addr[30]) stays downstream.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  system clock (post-divider CPU clock)
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request; held until m0_ack
- m0_wr  in  1  master 0: 1 = write, 0 = read
- m0_addr  in  ADDR_W  master 0 byte address
- m0_wdata  in  DATA_W  master 0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data, valid while m0_ack=1
- m1_req / m1_wr / m1_addr / m1_wdata / m1_ack / m1_rdata: same as m0_*, for master 1
- mem_rd  out  1  port read strobe
- mem_wr  out  1  port write strobe
- mem_addr  out  ADDR_W  port address
- mem_wdata  out  DATA_W  port write data
- mem_rdata  in  DATA_W  port read data (combinational from mem_addr)
- owner  out  1  index of the master owning the current or last transaction
- busy  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any request: pick the winner, latch its wr/addr/wdata and index into command registers, go to ACCESS.
- **ACCESS**
  - Registered mem_addr/mem_wdata are driven from the latched command.
  - mem_rd = ~wr, mem_wr = wr; both gated by ~reset.
  - mem_rdata is captured into the response register at the clock edge. Go to RESP.
- **RESP**
  - Assert ack of the latched owner; its rdata output = captured data (zero for writes).
  - The acked master is excluded from arbitration in this cycle.
  - If the other master requests: latch it and go straight to ACCESS.
  - Otherwise go to IDLE.
- Non-owner rdata is held at 0; non-owner ack is 0.
- Winner selection (IDLE): a single requester always wins. For simultaneous requests, see Configuration.
- Requester rules:
  - Command stays stable from raising req until ack.
  - req may stay high after ack to issue a new command. The new command must be presented the cycle after ack.
- Reset values:
  - State IDLE, owner=0, busy=0, all acks 0, all rdata 0.
  - mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - Round-robin pointer = 1, so master 0 wins first.
- Reset mid-transaction: the transaction is abandoned and never acked. No memory strobe is asserted in a cycle where reset=1.

## Timing
- req first high before edge E0 (state IDLE): ACCESS in cycle E0–E1, ack in cycle E1–E2.
- Request-to-ack latency: 2 cycles.
- Back-to-back alternating masters: one access per 2 cycles (RESP→ACCESS).
- Single master streaming: one access per 3 cycles (RESP→IDLE→ACCESS).
- owner and busy are registered; they change only at clock edges.

## Configuration
- ARB_RR_EN defined:
  - A 1-bit last-grant pointer is updated on every grant.
  - On a simultaneous request in IDLE, the master ≠ pointer wins.
- ARB_RR_EN undefined:
  - Fixed priority: master 0 always wins in IDLE.
  - The pointer register is absent.
- The RESP exclusion rule applies in both builds, so neither master is starved while the other streams.

## Structure
- Package bus_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP)
  - master index constants M_CPU=0, M_DMA=1
  - ADDR_W/DATA_W defaults
- Sub-module arb_pick: combinational 2-input picker.
  - Inputs: req vector, pointer, exclude mask.
  - Outputs: grant valid and index.
  - Instantiated once; the macro only changes the pointer input (tied to 1 when disabled).

## Test plan
- **Reset**: hold reset 2 cycles with m0_req=1 → no strobes, acks 0, busy 0; the first access starts the cycle after reset drops.
- **Single read**: m0 reads 0x0000_0010, memory returns 0xDEAD_BEEF → mem_rd one cycle later, m0_ack with m0_rdata=0xDEAD_BEEF exactly 2 cycles after req.
- **Single write**: m1 writes 0x1234_5678 to 0x4000_000C → one mem_wr cycle with matching addr/data; m1_ack 2 cycles later, m1_rdata=0.
- **Simultaneous requests, both high continuously**:
  - ARB_RR_EN build: grants m0, m1, m0, m1.
  - Fixed build: first grant m0, then alternation via RESP exclusion.
  - Both builds: one ack every 2 cycles.
- **Streaming**: only m0 requests 4 writes back-to-back → one ack per 3 cycles; addresses issued in order.
- **Reset in ACCESS cycle**: reset during a m1 write → mem_wr=0 that cycle, no m1_ack, state IDLE afterwards.
